// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory request/acknowledge bus between the multicycle controller and the
// shared memory port. master = controller, slave = memory.
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, one instruction at a time.
// Ports: clk, rst (sync, active-high); mem (req/we/adr_src/ack bus);
//   op_i, cond_pass_i from decoder; datapath strobes/muxes *_o;
//   retired_o pulse, illegal_o sticky fault, state_dbg_o state code.
// Optional: MCTRL_PERF_EN adds instr_count_o / cycle_count_o.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_fsm_if.master mem,
  input  logic [3:0]           op_i,
  input  logic                 cond_pass_i,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic [1:0]           pc_src_o,
  output logic                 reg_write_o,
  output logic [1:0]           result_src_o,
  output logic                 alu_src_b_o,
  output logic [3:0]           alu_ctrl_o,
  output logic                 flag_write_o,
  output logic                 retired_o,
  output logic                 illegal_o,
  output logic [3:0]           state_dbg_o
`ifdef MCTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     instr_count_o,
  output logic [CNT_W-1:0]     cycle_count_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_BXS    = 4'd9,
    S_FAULT  = 4'd10
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0111;
  localparam logic [3:0] OP_STR = 4'b1000;
  localparam logic [3:0] OP_B   = 4'b1001;
  localparam logic [3:0] OP_BX  = 4'b1010;

  // Wide enough to hold TIMEOUT_CYCLES itself.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic [TW-1:0] tmo_inc;

  logic       req, we, adr;
  logic       irw, pcw, rw, bsrc, fw, ret, ill;
  logic [1:0] pcs, rsrc;
  logic [3:0] alu;

  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES));
  assign tmo_inc = (TIMEOUT_CYCLES == 0) ? '0 : tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Counter defaults to 0 so it is clear on every entry to a wait state;
  // it only advances while a wait state is held without ack.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    req     = 1'b0;
    we      = 1'b0;
    adr     = 1'b0;
    irw     = 1'b0;
    pcw     = 1'b0;
    pcs     = 2'b00;
    rw      = 1'b0;
    rsrc    = 2'b00;
    bsrc    = 1'b0;
    alu     = 4'b0000;
    fw      = 1'b0;
    ret     = 1'b0;
    ill     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_DECODE: begin
        if (op_i > OP_BX) begin
          state_d = S_FAULT;
        end else if (!cond_pass_i) begin
          ret     = 1'b1;
          state_d = S_FETCH;
        end else begin
          unique case (1'b1)
            (op_i == OP_LDR),
            (op_i == OP_STR): state_d = S_MEMADR;
            (op_i == OP_B):   state_d = S_BRANCH;
            (op_i == OP_BX):  state_d = S_BXS;
            default:          state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu = op_i;
        if (op_i == OP_CMP) begin
          fw      = 1'b1;
          ret     = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        rw      = 1'b1;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        bsrc    = 1'b1;
        alu     = OP_ADD;
        state_d = (op_i == OP_LDR) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req = 1'b1;
        adr = 1'b1;
        if (mem.mem_ack) begin
          state_d = S_MEMWB;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_MEMWB: begin
        rw      = 1'b1;
        rsrc    = 2'b01;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        req = 1'b1;
        we  = 1'b1;
        adr = 1'b1;
        if (mem.mem_ack) begin
          ret     = 1'b1;
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_BRANCH: begin
        pcw     = 1'b1;
        pcs     = 2'b01;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_BXS: begin
        pcw     = 1'b1;
        pcs     = 2'b10;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: begin
        ill = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // Reset blanks every output, including ack-qualified strobes.
  assign mem.mem_req   = req  & ~rst;
  assign mem.mem_we    = we   & ~rst;
  assign mem.adr_src   = adr  & ~rst;
  assign ir_write_o    = irw  & ~rst;
  assign pc_write_o    = pcw  & ~rst;
  assign pc_src_o      = rst ? 2'b00 : pcs;
  assign reg_write_o   = rw   & ~rst;
  assign result_src_o  = rst ? 2'b00 : rsrc;
  assign alu_src_b_o   = bsrc & ~rst;
  assign alu_ctrl_o    = rst ? 4'b0000 : alu;
  assign flag_write_o  = fw   & ~rst;
  assign retired_o     = ret  & ~rst;
  assign illegal_o     = ill  & ~rst;
  assign state_dbg_o   = rst ? 4'b0000 : state_q;

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] icnt_q, ccnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (ret) icnt_q <= icnt_q + 1'b1;
      if (state_q != S_FAULT) ccnt_q <= ccnt_q + 1'b1;
    end
  end

  assign instr_count_o = icnt_q;
  assign cycle_count_o = ccnt_q;
`else
  logic unused_perf;
  assign unused_perf = (CNT_W > 0);
`endif

endmodule
